// File: rtl/mem_req_pkg.sv
// Shared types for the scratch-memory request controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_req_pkg;

  localparam int MEM_AW = 5;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } ctrl_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  typedef struct packed {
    mem_op_e             op;
    logic [MEM_AW-1:0]   addr;
    logic [MEM_DW-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered occupancy count.
// Latency: a pushed entry is visible at pop_data on the following cycle; pop_data is the head, read combinationally.
// Backpressure: pushes while full and pops while empty are ignored; full/empty/count come from registers only.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = store[rd_ptr];

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Sequences queued read/write requests onto the scratch memory bus and returns read data.
// Latency: accept in cycle 0, strobe in cycle 2, read response valid from cycle 3.
// Backpressure: req_ready drops when the request FIFO is full; a stalled response holds the FSM in RESP.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_data_out,
  output logic          busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ctrl_state_e   state;
  ctrl_state_e   state_nxt;
  mem_req_t      req_in;
  mem_req_t      fifo_head;
  mem_req_t      cmd;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          cmd_is_write;
  logic          rsp_fire;

  assign req_in.op    = req_write ? OP_WRITE : OP_READ;
  assign req_in.addr  = req_addr;
  assign req_in.wdata = req_wdata;

  // Ready comes from the registered count, so a same-cycle pop never frees a slot for a push.
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;

  sync_fifo #(
    .WIDTH ($bits(mem_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (req_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_is_write = (cmd.op == OP_WRITE);
  assign rsp_fire     = rsp_valid && rsp_ready;

  // The bus address/data follow the command register, so they hold their value outside ACCESS.
  assign mem_addr    = cmd.addr;
  assign mem_data_in = cmd.wdata;
  assign busy        = (fifo_count != '0) || (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; writes chain back-to-back, reads detour through RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!cmd_is_write)    state_nxt = RESP;
        else if (fifo_empty)  state_nxt = IDLE;
        else                  state_nxt = ACCESS;
      end
      RESP: begin
        if (rsp_fire) state_nxt = fifo_empty ? IDLE : ACCESS;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and FIFO pop; strobes are only ever asserted in ACCESS and are mutually exclusive.
  always_comb begin
    mem_write = 1'b0;
    mem_read  = 1'b0;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        fifo_pop = !fifo_empty;
      end
      ACCESS: begin
        mem_write = cmd_is_write;
        mem_read  = !cmd_is_write;
        fifo_pop  = cmd_is_write && !fifo_empty;
      end
      RESP: begin
        fifo_pop = rsp_fire && !fifo_empty;
      end
      default: begin
        fifo_pop = 1'b0;
      end
    endcase
  end

  // Command register and response holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (fifo_pop) begin
        cmd <= fifo_head;
      end
      if (state == ACCESS && !cmd_is_write) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_data_out;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl with an attached 32x8 memory.
// Latency: n/a (testbench).
// Backpressure: rsp_ready is driven both held and randomised.
module tb_mem_req_ctrl;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_data_out;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_req_ctrl #(.AW(AW), .DW(DW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(int i);
    if (i == 9)  return 8'h00;
    if (i == 31) return 8'h3C;
    return 8'((i * 37 + 11) & 8'hFF);
  endfunction

  // Scratch memory seen by the DUT: combinational read, write on clock edge.
  logic [7:0] env_mem [32];
  bit         env_loaded = 1'b0;
  assign mem_data_out = env_mem[mem_addr];

  always @(posedge clk) begin
    if (!env_loaded) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= init_val(i);
      env_loaded <= 1'b1;
    end else if (mem_write) begin
      env_mem[mem_addr] <= mem_data_in;
    end
  end

  // Reference model: in-order semantics applied at acceptance time.
  logic [7:0] ref_mem [32];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int         rsp_cnt = 0;
  int         both_viol = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor at the falling edge: handshakes seen here fire at the next rising edge.
  always @(negedge clk) begin
    if (mem_read && mem_write) both_viol++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("rsp_hold", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, prev_data});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_extra", 1, 0);
        else chk("rsp_data", rsp_data, exp_q.pop_front());
        got_q.push_back(rsp_data);
        rsp_cnt++;
      end
      if (req_valid && req_ready) begin
        if (req_write) ref_mem[req_addr] = req_wdata;
        else exp_q.push_back(ref_mem[req_addr]);
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
    end
  end

  task automatic send_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("req_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      ok = !busy && !rsp_valid && (exp_q.size() == 0);
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] wbits;
    logic [7:0] held;
    int base;
    int nreads;
    bit done;

    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_data_in, 0);
    chk("rst_strobes", {mem_write, mem_read}, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Write addr 5 then read it back, checking exact cycle positions
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd5; req_wdata = 8'hA5;
    @(negedge clk);
    chk("t1_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk); chk("t1_wr_c1", mem_write, 0);
    @(negedge clk); chk("t1_wr_c2", {mem_write, mem_read, mem_addr, mem_data_in}, {1'b1, 1'b0, 5'd5, 8'hA5});
    @(negedge clk); chk("t1_wr_c3", mem_write, 0);
    @(posedge clk);
    #1 req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk); chk("t1_rd_c1", {mem_read, rsp_valid}, 0);
    @(negedge clk); chk("t1_rd_c2", {mem_read, mem_write, rsp_valid}, {1'b1, 1'b0, 1'b0});
    @(negedge clk); chk("t1_rd_c3", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, 8'hA5});
    @(posedge clk);
    #1;
    wait_drain();

    // Four back-to-back writes: strobes in cycles 2..5
    wbits = '0;
    for (int i = 0; i < 8; i++) begin
      req_valid = (i < 4);
      req_write = 1'b1;
      req_addr  = AW'(i & 3);
      req_wdata = 8'h10 + 8'(i & 3);
      @(negedge clk);
      if (i < 4) chk("t2_ready", req_ready, 1);
      wbits[i] = mem_write;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("t2_wr_pattern", wbits, 8'b0011_1100);
    base = got_q.size();
    for (int i = 0; i < 4; i++) send_req(1'b0, AW'(i), 8'h00);
    wait_drain();
    for (int i = 0; i < 4; i++) chk("t2_readback", got_q[base + i], 8'h10 + 8'(i));

    // Stalled response: FIFO refills and req_ready drops
    rsp_ready = 1'b0;
    base = rsp_cnt;
    for (int i = 0; i < 5; i++) send_req(1'b0, AW'(10 + i), 8'h00);
    @(negedge clk);
    chk("t3_full", req_ready, 0);
    chk("t3_busy", busy, 1);
    held = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall", {23'd0, rsp_valid, rsp_data}, {23'd0, 1'b1, held});
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain();
    chk("t3_count", rsp_cnt - base, 5);

    // Top address, read-after-write ordering
    send_req(1'b0, 5'd31, 8'h00);
    send_req(1'b1, 5'd31, 8'hFF);
    send_req(1'b0, 5'd31, 8'h00);
    wait_drain();
    chk("t4_first", got_q[got_q.size() - 2], 8'h3C);
    chk("t4_second", got_q[got_q.size() - 1], 8'hFF);
    chk("t4_exclusive", both_viol, 0);

    // Reset during the write strobe cancels the write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd9; req_wdata = 8'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_strobe", mem_write, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_wr", mem_write, 0);
    chk("t5_rst_out", {rsp_valid, busy, req_ready, mem_read}, 4'b0010);
    @(posedge clk);
    #2 rst_n = 1'b1;
    ref_mem[9] = 8'h00;
    exp_q.delete();
    @(posedge clk);
    #1;
    send_req(1'b0, 5'd9, 8'h00);
    wait_drain();
    chk("t5_readback", got_q[got_q.size() - 1], 8'h00);
    chk("t5_envmem", env_mem[9], 8'h00);

    // Random traffic against the reference model
    base   = rsp_cnt;
    nreads = 0;
    done   = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          bit w;
          w = $urandom_range(1);
          if (!w) nreads++;
          repeat ($urandom_range(2)) begin
            @(posedge clk);
            #1;
          end
          send_req(w, AW'($urandom_range(31)), DW'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rsp_ready = ($urandom_range(3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    wait_drain();
    chk("t6_count", rsp_cnt - base, nreads);
    chk("t6_pending", exp_q.size(), 0);
    chk("t6_exclusive", both_viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
